// File: rtl/kv_way_refill_ctrl.sv
// Cache line refill sequencer: captures one miss, picks a victim way, fetches
// the line from memory and streams the beats into the data array.
module kv_way_refill_ctrl #(
    parameter int WAY_NUM  = 4,
    parameter int SET_NUM  = 64,
    parameter int BEAT_NUM = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    localparam int OFF_W   = $clog2(BEAT_NUM * DATA_W / 8),
    localparam int IDX_W   = $clog2(SET_NUM),
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W,
    localparam int WAY_W   = $clog2(WAY_NUM),
    localparam int BEAT_W  = $clog2(BEAT_NUM)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_miss_valid,
    output logic              o_miss_ready,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic [WAY_NUM-1:0] i_valid_way,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_wr_en,
    output logic [WAY_NUM-1:0] o_wr_way,
    output logic [BEAT_W-1:0] o_wr_beat,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_tag_we,
    output logic [IDX_W-1:0]  o_tag_set,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_done,
    output logic              o_busy
);

    // state     | meaning
    // S_IDLE    | waiting for a miss, o_miss_ready high
    // S_ALLOC   | one cycle: choose and register the victim way
    // S_MEM_REQ | line read request held until accepted
    // S_REFILL  | writing returned beats into the data array
    // S_COMMIT  | one cycle: write tag/valid, pulse done
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_MEM_REQ,
        S_REFILL,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAY_NUM-1:0] way_oh_q, way_oh_d;
    logic [WAY_W-1:0]   rr_q [SET_NUM];

    logic               inv_found;
    logic [WAY_W-1:0]   inv_idx;
    logic [WAY_W-1:0]   alloc_way;
    logic               rr_adv;

    // Descending scan so the lowest-index invalid way is the one left standing.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!i_valid_way[i]) begin
                inv_found = 1'b1;
                inv_idx   = WAY_W'(i);
            end
        end
    end

    assign alloc_way = inv_found ? inv_idx : rr_q[idx_q];
    assign rr_adv    = (state_q == S_ALLOC) && !inv_found;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        way_oh_d = way_oh_q;
        case (state_q)
            S_IDLE: begin
                if (i_miss_valid) begin
                    tag_d   = i_miss_addr[ADDR_W-1 -: TAG_W];
                    idx_d   = i_miss_addr[OFF_W +: IDX_W];
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                way_oh_d = WAY_NUM'(1) << alloc_way;
                state_d  = S_MEM_REQ;
            end
            S_MEM_REQ: begin
                if (i_mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (i_mem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEAT_NUM - 1)) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            way_oh_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            way_oh_q <= way_oh_d;
        end
    end

    // Per-set round-robin pointers advance only when an all-valid set is allocated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SET_NUM; s++) begin
                rr_q[s] <= '0;
            end
        end else if (rr_adv) begin
            rr_q[idx_q] <= rr_q[idx_q] + 1'b1;
        end
    end

    always_comb begin
        o_miss_ready    = (state_q == S_IDLE);
        o_busy          = (state_q != S_IDLE);
        o_mem_req_valid = (state_q == S_MEM_REQ);
        o_mem_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
        o_wr_en         = (state_q == S_REFILL) && i_mem_rvalid;
        o_wr_way        = way_oh_q;
        o_wr_beat       = beat_q;
        o_wr_data       = o_wr_en ? i_mem_rdata : '0;
        o_tag_we        = (state_q == S_COMMIT);
        o_done          = (state_q == S_COMMIT);
        o_tag_set       = idx_q;
        o_tag           = tag_q;
    end

endmodule

// File: tb/tb_kv_way_refill_ctrl.sv
// Randomized self-checking bench for kv_way_refill_ctrl against a
// behavioural model of victim selection and refill sequencing.
module tb_kv_way_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [3:0]  valid_way;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wr_en;
    logic [3:0]  wr_way;
    logic [1:0]  wr_beat;
    logic [31:0] wr_data;
    logic        tag_we;
    logic [5:0]  tag_set;
    logic [21:0] tag;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int rr_m [64];

    kv_way_refill_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_miss_valid    (miss_valid),
        .o_miss_ready    (miss_ready),
        .i_miss_addr     (miss_addr),
        .i_valid_way     (valid_way),
        .o_mem_req_valid (req_valid),
        .i_mem_req_ready (req_ready),
        .o_mem_req_addr  (req_addr),
        .i_mem_rvalid    (rvalid),
        .i_mem_rdata     (rdata),
        .o_wr_en         (wr_en),
        .o_wr_way        (wr_way),
        .o_wr_beat       (wr_beat),
        .o_wr_data       (wr_data),
        .o_tag_we        (tag_we),
        .o_tag_set       (tag_set),
        .o_tag           (tag),
        .o_done          (done),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Victim rule: lowest invalid way, else the set's round-robin pointer (which then advances).
    function automatic int exp_victim(input logic [3:0] v, input int set);
        int r;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) return i;
        end
        r = rr_m[set];
        rr_m[set] = (r + 1) % 4;
        return r;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 64; s++) rr_m[s] = 0;
    endtask

    task automatic check_quiet_reset();
        chk("rst_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_way", wr_way, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_done", done, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_tag", tag, 0);
        chk("rst_set", tag_set, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            miss_valid = 1'b0;
            rvalid     = 1'($urandom % 2);
            rdata      = $urandom;
            #1;
            chk("idle_wr_en", wr_en, 0);
            chk("idle_ready", miss_ready, 1);
        end
    endtask

    // rv_mode: 0 rvalid every cycle, 1 fixed gap pattern, 2 random.
    // abort_beat >= 0 asserts reset when that many beats have been written.
    task automatic do_refill(input logic [31:0] addr, input logic [3:0] vway,
                             input int req_dly, input int rv_mode, input int abort_beat);
        int vic, beat, guard, p, set;
        logic [21:0] etag;
        logic [3:0]  eoh;
        logic [6:0]  pat;
        logic        rv;
        pat  = 7'b1011001;
        set  = int'((addr >> 4) & 32'h3F);
        etag = 22'(addr >> 10);

        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = addr;
        valid_way  = vway;
        rvalid     = 1'b0;
        #1;
        chk("miss_ready", miss_ready, 1);
        vic = exp_victim(vway, set);
        eoh = 4'(1 << vic);
        @(posedge clk);

        @(negedge clk);
        miss_valid = 1'($urandom % 2);
        rvalid     = 1'($urandom % 2);
        #1;
        chk("alloc_ready", miss_ready, 0);
        chk("alloc_busy", busy, 1);
        chk("alloc_wr_en", wr_en, 0);
        chk("alloc_req_valid", req_valid, 0);
        @(posedge clk);

        for (int k = 0; k <= req_dly; k++) begin
            @(negedge clk);
            miss_valid = 1'($urandom % 2);
            req_ready  = (k == req_dly);
            rvalid     = 1'($urandom % 2);
            #1;
            chk("req_valid", req_valid, 1);
            chk("req_addr", req_addr, addr & ~32'hF);
            chk("req_wr_en", wr_en, 0);
            chk("req_ready_lo", miss_ready, 0);
            chk("req_wr_way", wr_way, eoh);
            @(posedge clk);
        end

        beat = 0; p = 0; guard = 0;
        while (beat < 4) begin
            @(negedge clk);
            miss_valid = 1'b0;
            req_ready  = 1'b0;
            if (beat == abort_beat) begin
                rst_n  = 1'b0;
                rvalid = 1'b0;
                #1;
                check_quiet_reset();
                clear_model();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_tag_we", tag_we, 0);
                end
                rst_n = 1'b1;
                return;
            end
            if (rv_mode == 0) rv = 1'b1;
            else if (rv_mode == 1) rv = (p < 7) ? pat[p] : 1'b1;
            else rv = ($urandom % 10) < 6;
            p++;
            rvalid = rv;
            rdata  = $urandom;
            #1;
            chk("wr_en", wr_en, rv);
            if (rv) begin
                chk("wr_beat", wr_beat, beat);
                chk("wr_data", wr_data, rdata);
                chk("wr_way", wr_way, eoh);
            end
            chk("refill_tag_we", tag_we, 0);
            chk("refill_done", done, 0);
            @(posedge clk);
            if (rv) beat++;
            guard++;
            if (guard > 100) begin
                chk("refill_bound", 0, 1);
                break;
            end
        end

        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("commit_tag_we", tag_we, 1);
        chk("commit_done", done, 1);
        chk("commit_set", tag_set, set);
        chk("commit_tag", tag, etag);
        chk("commit_way", wr_way, eoh);
        chk("commit_wr_en", wr_en, 0);
        @(posedge clk);

        @(negedge clk);
        rvalid = 1'($urandom % 2);
        #1;
        chk("post_done", done, 0);
        chk("post_tag_we", tag_we, 0);
        chk("post_ready", miss_ready, 1);
        chk("post_wr_en", wr_en, 0);
        chk("post_wr_way", wr_way, eoh);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  v;
        clear_model();
        rst_n      = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        valid_way  = '0;
        req_ready  = 1'b0;
        rvalid     = 1'b1;
        rdata      = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        check_quiet_reset();
        rvalid = 1'b0;
        rst_n  = 1'b1;

        do_refill(32'h0000_0040, 4'b0000, 0, 0, -1);
        do_refill(32'h1234_0070, 4'b1011, 0, 0, -1);
        do_refill(32'h5678_0070, 4'b0111, 0, 0, -1);
        do_refill(32'h9ABC_0070, 4'b1111, 0, 0, -1);

        for (int i = 0; i < 5; i++) do_refill(32'h0100_0050 + (i << 12), 4'b1111, 0, 0, -1);
        do_refill(32'h0200_0060, 4'b1111, 0, 0, -1);

        do_refill(32'hCAFE_0080, 4'b0001, 3, 1, -1);
        idle_cycles(4);

        do_refill(32'h0300_0050, 4'b1111, 0, 0, 2);
        do_refill(32'h0400_0050, 4'b1111, 0, 0, -1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom & ~32'h380;
            v = ($urandom % 2) ? 4'hF : 4'($urandom);
            do_refill(a, v, int'($urandom % 4), 2, -1);
            if ($urandom % 3 == 0) idle_cycles(int'($urandom % 3) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kv_way_refill_ctrl.md
Name: kv_way_refill_ctrl

Overview:
- Sequences a cache line refill after a miss: accepts one miss, picks a victim way, requests the line from memory, and streams the returned beats into the data array.
- Victim rule: lowest-index invalid way if one exists, otherwise a per-set round-robin way.
- On the last beat it writes tag/valid and pulses done.
- Sits between the cache miss detector, the tag/valid array and the memory bus; handles one refill at a time.

Parameters:
- WAY_NUM, 4, number of ways; power of two, >=2.
- SET_NUM, 64, number of sets; power of two.
- BEAT_NUM, 4, data beats per line; power of two, >=2.
- DATA_W, 32, beat width in bits.
- ADDR_W, 32, byte address width.
- Derived:
  - OFF_W = log2(BEAT_NUM*DATA_W/8)
  - IDX_W = log2(SET_NUM)
  - TAG_W = ADDR_W-IDX_W-OFF_W
  - WAY_W = log2(WAY_NUM)
  - BEAT_W = log2(BEAT_NUM)

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_miss_valid  in  1  miss request valid.
- o_miss_ready  out  1  controller can accept a miss.
- i_miss_addr  in  ADDR_W  missing byte address.
- i_valid_way  in  WAY_NUM  valid bits of the captured set (o_tag_set); sampled in ALLOC.
- o_mem_req_valid  out  1  line read request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_addr  out  ADDR_W  line-aligned address {tag,index,OFF_W'0}.
- i_mem_rvalid  in  1  read data beat valid.
- i_mem_rdata  in  DATA_W  read data beat.
- o_wr_en  out  1  data array write strobe.
- o_wr_way  out  WAY_NUM  one-hot victim way.
- o_wr_beat  out  BEAT_W  beat index within line.
- o_wr_data  out  DATA_W  beat data.
- o_tag_we  out  1  tag/valid write strobe.
- o_tag_set  out  IDX_W  captured set index (also data array set).
- o_tag  out  TAG_W  captured tag.
- o_done  out  1  one-cycle refill-complete pulse.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, beat counter=0, all round-robin pointers=0, captured addr=0, victim=0.
  - All outputs 0 except o_miss_ready=1.
- FSM states: IDLE, ALLOC, MEM_REQ, REFILL, COMMIT.
- IDLE:
  - o_miss_ready=1.
  - On i_miss_valid&o_miss_ready: capture tag/index, go ALLOC.
- ALLOC (exactly 1 cycle), sampling i_valid_way:
  - If any bit is 0: victim = lowest index with bit 0; rr pointer unchanged.
  - If all bits are 1: victim = rr_ptr[set], and rr_ptr[set] <= rr_ptr[set]+1 mod WAY_NUM.
  - Victim is registered; go MEM_REQ.
- MEM_REQ:
  - o_mem_req_valid=1 with o_mem_req_addr held stable until handshake.
  - On i_mem_req_ready: go REFILL, beat=0.
- REFILL:
  - Each cycle with i_mem_rvalid=1, combinationally in the same cycle:
    - o_wr_en=1
    - o_wr_way=onehot(victim)
    - o_wr_beat=beat
    - o_wr_data=i_mem_rdata
  - beat increments on each valid beat.
  - When the beat with index BEAT_NUM-1 is written, go COMMIT.
  - Gaps in i_mem_rvalid allowed; the controller waits.
- COMMIT (1 cycle):
  - o_tag_we=1, o_done=1, o_wr_way=victim, o_tag/o_tag_set = captured values.
  - Next state IDLE.
- o_miss_ready is 0 in every state except IDLE; back-to-back misses have a minimum 1-cycle gap after o_done.
- i_mem_rvalid outside REFILL is ignored: no write, no counter change.
- o_wr_way, o_tag, o_tag_set hold the captured/victim values from ALLOC onward until the next capture.
- Cycle count with zero-wait memory and rvalid every cycle, from miss handshake to o_done: ALLOC 1 + MEM_REQ 1 + BEAT_NUM + COMMIT 1.
- Reset asserted mid-operation:
  - Refill aborts; no o_tag_we is issued.
  - Pointers clear; the partially written line stays invalid because valid is never set.
- Each rr pointer is per set (SET_NUM x WAY_W bits) and updates only in ALLOC with an all-valid set.

Test Plan:
- Reset, miss addr 0x0000_0040, i_valid_way=4'b0000 -> victim way0, mem addr 0x40, 4 beats written o_wr_way=0001 beats 0..3, o_tag_we with set 4, tag 0, o_done pulse 7 cycles after handshake.
- i_valid_way=4'b1011 -> o_wr_way=0100; i_valid_way=4'b0111 -> 1000; rr pointer of that set stays 0.
- Set 5 full (4'b1111), five consecutive misses -> victims way0,1,2,3,0; a miss to set 6 full -> way0 (independent pointer).
- i_mem_req_ready low 3 cycles and i_mem_rvalid pattern 1,0,0,1,1,0,1 -> request held stable, exactly 4 writes with beats 0..3 in order, single o_done.
- Stray i_mem_rvalid in IDLE/MEM_REQ -> no o_wr_en; i_miss_valid while busy -> not accepted (o_miss_ready=0).
- Assert i_rst_n=0 after beat 1 of a refill -> outputs clear immediately, no o_tag_we, next miss to full set restarts at way0.
